// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_pkg
// Brief   : Hex glyph table and the decode function for active-high
//           abcdefg segment patterns.
// Revision: 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    // Seven-segment glyphs on pattern bits [7:1] (a..g). Entry i is hex digit i.
    localparam logic [16*7-1:0] c_glyph_table = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    // Returns {valid, code}. Code is 0 when the pattern is not a hex glyph.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] w_result;
        w_result = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (c_glyph_table[7*i +: 7] == seg) begin
                w_result = {1'b1, 4'(i)};
            end
        end
        return w_result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_sample_filter.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_sample_filter
// Brief   : Two-flop synchroniser plus dwell run counter; strobes once per
//           stable dwell with the settled digit/pattern.
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_sample_filter #(
    parameter int W_DIGIT       = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         i_abcdefgh,
    input  logic [W_DIGIT-1:0] i_digit,
    output logic               o_capture,
    output logic               o_multi,
    output logic [W_DIGIT-1:0] o_digit,
    output logic [7:0]         o_pattern
);

    localparam logic [7:0] c_run_sat = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_run_arm = 8'(STABLE_CYCLES - 2);

    logic [W_DIGIT+7:0] r_sync1;
    logic [W_DIGIT+7:0] r_sync2;
    logic [7:0]         r_run;
    logic               r_capture;
    logic               r_multi;
    logic [W_DIGIT-1:0] r_digit;
    logic [7:0]         r_pattern;

    logic               w_same;
    logic               w_arm;
    logic [W_DIGIT-1:0] w_dig;
    logic               w_nonzero;
    logic               w_onehot;

    assign w_same    = (r_sync1 == r_sync2);
    assign w_arm     = w_same && (r_run == c_run_arm);
    assign w_dig     = r_sync2[W_DIGIT+7:8];
    assign w_nonzero = (w_dig != '0);
    assign w_onehot  = w_nonzero &&
                       ((w_dig & (w_dig - {{(W_DIGIT-1){1'b0}}, 1'b1})) == '0);

    // The strobe is registered on the edge the run counter reaches STABLE_CYCLES-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_run     <= '0;
            r_capture <= 1'b0;
            r_multi   <= 1'b0;
            r_digit   <= '0;
            r_pattern <= '0;
        end else begin
            r_sync1   <= {i_digit, i_abcdefgh};
            r_sync2   <= r_sync1;
            if (!w_same) begin
                r_run <= '0;
            end else if (r_run != c_run_sat) begin
                r_run <= r_run + 8'd1;
            end
            r_capture <= w_arm && w_onehot;
            r_multi   <= w_arm && w_nonzero && !w_onehot;
            if (w_arm) begin
                r_digit   <= w_dig;
                r_pattern <= r_sync2[7:0];
            end
        end
    end

    assign o_capture = r_capture;
    assign o_multi   = r_multi;
    assign o_digit   = r_digit;
    assign o_pattern = r_pattern;

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan_decoder
// Brief   : Recovers per-digit hex values from a multiplexed seven-segment
//           scan, with frame tracking, multi-digit error and staleness timeout.
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder #(
    parameter int W_DIGIT        = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           abcdefgh,
    input  logic [W_DIGIT-1:0]   digit,
    output logic [W_DIGIT*4-1:0] char_code,
    output logic [W_DIGIT-1:0]   char_valid,
    output logic [W_DIGIT-1:0]   char_dp,
    output logic                 update,
    output logic                 frame_done,
    output logic [W_DIGIT-1:0]   seen_mask,
    output logic                 err_multi,
    output logic                 stale
);

    import seven_seg_pkg::*;

    localparam logic [19:0] c_tmo_max  = 20'(TIMEOUT_CYCLES);
    localparam logic [19:0] c_tmo_last = 20'(TIMEOUT_CYCLES - 1);

    logic                 w_cap;
    logic                 w_multi;
    logic [W_DIGIT-1:0]   w_sdig;
    logic [7:0]           w_spat;
    logic [4:0]           w_dec;
    logic                 w_tmo_hit;
    logic [W_DIGIT*4-1:0] w_code_nxt;
    logic [W_DIGIT-1:0]   w_valid_nxt;
    logic [W_DIGIT-1:0]   w_dp_nxt;

    logic [W_DIGIT*4-1:0] r_code;
    logic [W_DIGIT-1:0]   r_valid;
    logic [W_DIGIT-1:0]   r_dp;
    logic                 r_update;
    logic                 r_frame_done;
    logic [W_DIGIT-1:0]   r_seen;
    logic [W_DIGIT-1:0]   r_seen_mask;
    logic                 r_err;
    logic                 r_stale;
    logic [19:0]          r_tmo;

    seven_seg_sample_filter #(
        .W_DIGIT       (W_DIGIT),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .i_abcdefgh (abcdefgh),
        .i_digit    (digit),
        .o_capture  (w_cap),
        .o_multi    (w_multi),
        .o_digit    (w_sdig),
        .o_pattern  (w_spat)
    );

    assign w_dec = decode_glyph(w_spat[7:1]);

    // A capture on the expiry edge wins over the timeout.
    assign w_tmo_hit = !w_cap && (r_tmo == c_tmo_last);

    for (genvar gi = 0; gi < W_DIGIT; gi++) begin : g_slot
        logic w_hit;
        assign w_hit                  = w_cap && w_sdig[gi];
        assign w_code_nxt[4*gi +: 4]  = w_hit ? w_dec[3:0] : r_code[4*gi +: 4];
        assign w_valid_nxt[gi]        = w_hit ? w_dec[4] : (w_tmo_hit ? 1'b0 : r_valid[gi]);
        assign w_dp_nxt[gi]           = w_hit ? w_spat[0] : r_dp[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_code       <= '0;
            r_valid      <= '0;
            r_dp         <= '0;
            r_update     <= 1'b0;
            r_frame_done <= 1'b0;
            r_seen       <= '0;
            r_seen_mask  <= '0;
            r_err        <= 1'b0;
            r_stale      <= 1'b0;
            r_tmo        <= '0;
        end else begin
            r_code       <= w_code_nxt;
            r_valid      <= w_valid_nxt;
            r_dp         <= w_dp_nxt;
            r_update     <= ({w_code_nxt, w_valid_nxt, w_dp_nxt} != {r_code, r_valid, r_dp});
            r_err        <= w_multi;
            r_frame_done <= 1'b0;
            if (w_cap) begin
                r_tmo   <= '0;
                r_stale <= 1'b0;
                // Revisiting a slot closes the frame; the new frame starts with it.
                if ((r_seen & w_sdig) != '0) begin
                    r_frame_done <= 1'b1;
                    r_seen_mask  <= r_seen;
                    r_seen       <= w_sdig;
                end else begin
                    r_seen <= r_seen | w_sdig;
                end
            end else if (r_tmo != c_tmo_max) begin
                r_tmo <= r_tmo + 20'd1;
                if (w_tmo_hit) begin
                    r_stale <= 1'b1;
                end
            end
        end
    end

    assign char_code  = r_code;
    assign char_valid = r_valid;
    assign char_dp    = r_dp;
    assign update     = r_update;
    assign frame_done = r_frame_done;
    assign seen_mask  = r_seen_mask;
    assign err_multi  = r_err;
    assign stale      = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_scan_decoder
// Brief   : Directed self-checking bench; a second instance uses a short
//           timeout to exercise staleness.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  abcdefgh;
    logic [7:0]  digit;

    logic [31:0] char_code,  char_code_t;
    logic [7:0]  char_valid, char_valid_t;
    logic [7:0]  char_dp,    char_dp_t;
    logic        update,     update_t;
    logic        frame_done, frame_done_t;
    logic [7:0]  seen_mask,  seen_mask_t;
    logic        err_multi,  err_multi_t;
    logic        stale,      stale_t;

    int checks   = 0;
    int failures = 0;
    int n_upd    = 0;
    int n_frame  = 0;
    int n_err    = 0;
    logic [7:0] last_mask = 8'h00;
    int u0, f0, e0;

    seven_seg_scan_decoder #(
        .W_DIGIT(8), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(65535)
    ) dut (
        .clk(clk), .rst(rst), .abcdefgh(abcdefgh), .digit(digit),
        .char_code(char_code), .char_valid(char_valid), .char_dp(char_dp),
        .update(update), .frame_done(frame_done), .seen_mask(seen_mask),
        .err_multi(err_multi), .stale(stale)
    );

    seven_seg_scan_decoder #(
        .W_DIGIT(8), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut_t (
        .clk(clk), .rst(rst), .abcdefgh(abcdefgh), .digit(digit),
        .char_code(char_code_t), .char_valid(char_valid_t), .char_dp(char_dp_t),
        .update(update_t), .frame_done(frame_done_t), .seen_mask(seen_mask_t),
        .err_multi(err_multi_t), .stale(stale_t)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (update)     n_upd++;
        if (err_multi)  n_err++;
        if (frame_done) begin
            n_frame++;
            last_mask = seen_mask;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; digit = 8'h00; abcdefgh = 8'h00;
        tick(2);
        rst = 1'b1;
    endtask

    logic [7:0] scan_dig [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    logic [7:0] scan_pat [4] = '{8'h60, 8'hB6, 8'hDA, 8'h1C};

    initial begin
        rst = 1'b0; digit = 8'h00; abcdefgh = 8'h00;
        tick(3);
        check_eq("reset_code",  char_code, 0);
        check_eq("reset_flags", {char_valid, char_dp, seen_mask}, 0);
        check_eq("reset_pulse", {update, frame_done, err_multi, stale}, 0);
        check_eq("reset_t",     {char_valid_t, stale_t}, 0);

        // Held pattern: latency 6, one update, nothing afterwards.
        rst = 1'b1; digit = 8'h01; abcdefgh = 8'hFC;
        u0 = n_upd;
        tick(5);
        check_eq("latency_early", char_valid, 8'h00);
        tick(1);
        check_eq("hold_valid", {char_code[3:0], char_valid, char_dp}, {4'h0, 8'h01, 8'h00});
        check_eq("hold_update", update, 1);
        tick(100);
        check_eq("hold_quiet", n_upd - u0, 1);

        // Scan of four digits then slot0 again closes the frame.
        do_reset();
        u0 = n_upd; f0 = n_frame;
        for (int i = 0; i < 4; i++) begin
            digit = scan_dig[i]; abcdefgh = scan_pat[i];
            tick(20);
        end
        digit = 8'h01; abcdefgh = 8'h60;
        tick(20);
        check_eq("scan_codes", char_code, 32'h0000_0251);
        check_eq("scan_valid", char_valid, 8'h07);
        check_eq("scan_updates", n_upd - u0, 3);
        check_eq("scan_frames", n_frame - f0, 1);
        check_eq("scan_mask", last_mask, 8'h0F);

        // Blank glyph with decimal point: invalid, dp captured.
        digit = 8'h10; abcdefgh = 8'h01;
        tick(20);
        check_eq("blank_dp", {char_dp, char_valid}, {8'h10, 8'h07});
        check_eq("blank_update", n_upd - u0, 4);

        // Two digits lit at once.
        u0 = n_upd; e0 = n_err;
        digit = 8'h03; abcdefgh = 8'hFC;
        tick(20);
        check_eq("multi_err", n_err - e0, 1);
        check_eq("multi_noupd", n_upd - u0, 0);
        check_eq("multi_slots", {char_code, char_valid}, {32'h0000_0251, 8'h07});

        // Pattern toggling faster than the dwell length.
        u0 = n_upd; e0 = n_err;
        for (int k = 0; k < 10; k++) begin
            digit = 8'h20; abcdefgh = (k % 2 == 1) ? 8'h60 : 8'hFC;
            tick(3);
        end
        digit = 8'h00;
        tick(10);
        check_eq("toggle_noupd", n_upd - u0, 0);
        check_eq("toggle_slots", {char_valid, n_err - e0}, {8'h07, 32'd0});

        // Timeout expiry on the short-timeout instance.
        do_reset();
        digit = 8'h01; abcdefgh = 8'hFC;
        tick(6);
        check_eq("tmo_cap", {char_valid_t, stale_t}, {8'h01, 1'b0});
        digit = 8'h00;
        tick(15);
        check_eq("tmo_before", {char_valid_t, stale_t}, {8'h01, 1'b0});
        tick(1);
        check_eq("tmo_expire", {char_valid_t, stale_t, update_t}, {8'h00, 1'b1, 1'b1});
        digit = 8'h02; abcdefgh = 8'h60;
        tick(6);
        check_eq("tmo_recover", {char_valid_t, stale_t, char_code_t[7:4]}, {8'h02, 1'b0, 4'h1});

        // Reset in the middle of a dwell.
        digit = 8'h04; abcdefgh = 8'h66;
        tick(3);
        rst = 1'b0;
        tick(2);
        check_eq("midrst_zero", {char_code, char_valid, char_dp, seen_mask, update, stale}, 0);
        rst = 1'b1;
        tick(5);
        check_eq("midrst_early", char_valid, 8'h00);
        tick(1);
        check_eq("midrst_cap", {char_valid, char_code[11:8]}, {8'h04, 4'h4});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 Parameter w_digit, default 8: number of scanned digit positions.
REQ-002 Parameter stable_cycles, default 4: consecutive identical samples required before a capture (legal range 2..255).
REQ-003 Parameter timeout_cycles, default 65535: cycles without any capture before all slots are invalidated (legal range 16..2^20-1).
REQ-004 clk  in  1: single clock; all logic rising-edge on clk.
REQ-005 rst  in  1: synchronous, active-low reset.
REQ-006 abcdefgh  in  8: segment pattern; bit7 = a ... bit1 = g, bit0 = h (decimal point); active-high.
REQ-007 digit  in  w_digit: digit enables, active-high, expected one-hot or zero.
REQ-008 char_code  out  w_digit*4: per-slot decoded hex value; slot i occupies bits [4i+3:4i].
REQ-009 char_valid  out  w_digit: per-slot flag, 1 = last capture was a recognised hex glyph.
REQ-010 char_dp  out  w_digit: per-slot captured decimal point (bit0 of pattern).
REQ-011 update  out  1: one-cycle pulse when any slot's {code, valid, dp} changes.
REQ-012 frame_done  out  1: one-cycle pulse when a scan frame completes.
REQ-013 seen_mask  out  w_digit: slots captured in the most recently completed frame.
REQ-014 err_multi  out  1: one-cycle pulse per dwell when digit is non-zero and not one-hot.
REQ-015 stale  out  1: high while the timeout has expired and no capture has occurred since.

Function
REQ-016 abcdefgh and digit SHALL each pass a 2-flop synchroniser before any use.
REQ-017 Dwell: a maximal run of edges with an unchanged synchronised {digit, abcdefgh}; a run counter resets to 0 on any change and saturates at stable_cycles.
REQ-018 A capture SHALL occur exactly once per dwell, on the edge where the run counter reaches stable_cycles-1, if and only if digit is one-hot.
REQ-019 Pin-to-output latency for a held pattern SHALL be 2 + stable_cycles cycles (6 at default).
REQ-020 digit == 0: no capture, no error; the run counter still operates.
REQ-021 digit non-zero and not one-hot: no capture; err_multi pulses once at the capture point of that dwell.
REQ-022 Decode table on bits [7:1] (dp ignored): 0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=70,8=7F,9=7B,A=77,b=1F,C=4E,d=3D,E=4F,F=47.
REQ-023 Unmatched pattern (incl. blank): slot code SHALL be 0, valid 0, dp still captured.
REQ-024 update SHALL pulse in the cycle the slot registers take their new value, only if the value differs from the stored one.
REQ-025 Frame tracking: a seen register accumulates captured slots; a capture into an already-seen slot SHALL pulse frame_done, load seen_mask with the seen value, and reset seen to that slot only.
REQ-026 Timeout counter SHALL clear on every capture; on reaching timeout_cycles it SHALL clear all char_valid, assert stale and hold (saturate); update pulses if any valid bit changed.
REQ-027 The first capture after stale SHALL deassert stale in the same cycle the slot is written.
REQ-028 Capture and timeout expiry on the same edge: capture wins, the counter clears, stale stays low.

Reset
REQ-029 While rst is low: sync flops, run counter, seen, timeout counter and all outputs SHALL be 0.
REQ-030 Reset mid-dwell SHALL abandon the dwell; after release a full 2 + stable_cycles cycles are needed before a capture.

Structure
REQ-031 Package seven_seg_pkg SHALL hold the glyph constants of REQ-022 and a decode function shared with the display driver.
REQ-032 The synchroniser and run counter SHALL form one sub-module, seven_seg_sample_filter, emitting a capture strobe plus the stable {digit, abcdefgh}.

Verification
REQ-033 digit=01, abcdefgh=FC held 6 cycles -> slot0 code 0, valid 1, dp 0, one update pulse; held 100 more cycles -> no further pulses.
REQ-034 Scan 0x01/60, 0x02/B6, 0x04/DA, 0x08/1C, 20 cycles each, then 0x01 again -> codes 1,5,2; slot3 valid 0; frame_done pulses at the second slot0 capture with seen_mask=0x0F.
REQ-035 digit=03 for 20 cycles -> exactly one err_multi pulse, no update, slots unchanged.
REQ-036 Pattern toggles every 3 cycles (stable_cycles=4) -> no capture, no update.
REQ-037 timeout_cycles=16, valid capture then digit=0 -> 16 cycles after capture all valid 0, stale 1, one update; next capture -> stale 0.
REQ-038 rst low 2 cycles 3 cycles into a dwell -> outputs 0; capture exactly 6 cycles after release.
